rx_crc15_unit: RTL and testbench
================================

RX_CRC15_UNIT -- requirements
Module: rx_crc15_unit

Interface
REQ-001 SHALL have port: clock  in  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset (sampled on clock rising edge).
REQ-003 SHALL have port: start  in  1  pulse; clears the CRC register and begins a frame.
REQ-004 SHALL have port: enable  in  1  bit strobe; one bit is taken per low-to-high transition.
REQ-005 SHALL have port: Input  in  1  destuffed received bit.
REQ-006 SHALL have port: check  in  1  pulse; ends the frame and evaluates the remainder.
REQ-007 SHALL have port: crc  out  15  current CRC register value.
REQ-008 SHALL have port: crc_ok  out  1  remainder zero at check.
REQ-009 SHALL have port: crc_err  out  1  check failed.
REQ-010 SHALL have port: bitcnt  out  7  bits shifted since start (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE, with IDLE left on reset.
REQ-012 SHALL, in any state on start=1: set crc=0, set crc_ok=0 and crc_err=0, set bitcnt=0, and move to CALC.
REQ-013 SHALL keep an edge flag: set on the first cycle with enable=1, cleared on the first cycle with enable=0; a bit event is enable=1 with flag=0.
REQ-014 SHALL, in CALC on a bit event, update crc with fb = Input XOR crc[14] to crc_next = {crc[13:0],0} XOR (fb ? 15'h4599 : 0), taking effect next cycle.
REQ-015 SHALL take exactly one bit per enable high period, regardless of its length.
REQ-016 SHALL, in CALC on check=1: set crc_ok=(crc==0), set crc_err=!crc_ok and move to DONE; a coincident bit event is discarded.
REQ-017 SHALL make start win over check and over a bit event in the same cycle; that bit is discarded but the edge flag is still set.
REQ-018 SHALL ignore bit events and check in IDLE and DONE, while the edge flag still tracks enable.
REQ-019 SHALL hold crc_ok/crc_err stable in DONE until the next start or reset.
REQ-020 SHALL keep crc_ok and crc_err mutually exclusive at all times, both 0 outside DONE.

Reset
REQ-021 SHALL, on reset=0 at a clock edge, set crc=15'h0000, crc_ok=0, crc_err=0, bitcnt=0, edge flag=0 and state=IDLE, overriding start/check/enable.
REQ-022 SHALL abort a frame fully when reset occurs mid-frame; a later start is needed to resume.

Configuration
REQ-023 SHALL use the macro RCRC_LENGTH_CHECK_EN.
REQ-024 SHALL, when RCRC_LENGTH_CHECK_EN is defined: increment bitcnt per accepted bit, saturating at 127, and at check force crc_err=1, crc_ok=0 if bitcnt<15.
REQ-025 SHALL, when RCRC_LENGTH_CHECK_EN is undefined: tie bitcnt to 0, and base the check on the remainder only.

Verification
REQ-026 SHALL cover: reset=0 with start=1, enable toggling -> crc=0, crc_ok=0, crc_err=0, state IDLE.
REQ-027 SHALL cover: start, one enable pulse with Input=1 -> crc=15'h4599; a second pulse with Input=0 -> crc=15'h4EAB.
REQ-028 SHALL cover: after bits 1,0, shift 15'h4EAB MSB first, then check -> crc=0, crc_ok=1, crc_err=0; with RCRC_LENGTH_CHECK_EN, bitcnt=17.
REQ-029 SHALL cover: the same, with one remainder bit flipped -> crc_err=1, crc_ok=0; enable held high 10 cycles -> only one bit taken (bitcnt +1).
REQ-030 SHALL cover: start and check in the same cycle -> CALC, crc=0, flags 0; check in IDLE -> no change.
REQ-031 SHALL cover: with RCRC_LENGTH_CHECK_EN, start, shift 5 zero bits, check -> crc=0 yet crc_err=1; without the macro -> crc_ok=1.

Source files
------------

// File: rtl/rx_crc15_unit.sv
`default_nettype none
// ============================================================================
// Module      : rx_crc15_unit
// Description : Receive-side CRC-15 checker (generator 0x4599). Shifts one
//               destuffed bit per rising edge of the bit strobe between a
//               start pulse and a check pulse, then reports whether the
//               remainder is zero.
//               Optional build macro RCRC_LENGTH_CHECK_EN adds a saturating
//               bit counter and flags frames shorter than 15 bits as errors.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_crc15_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        enable,
    input  logic        Input,
    input  logic        check,
    output logic [14:0] crc,
    output logic        crc_ok,
    output logic        crc_err,
    output logic [6:0]  bitcnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [14:0] POLY = 15'h4599;

    state_t      state_q, state_d;
    logic [14:0] crc_q,   crc_d;
    logic        ok_q,    ok_d;
    logic        err_q,   err_d;
    logic        edge_q;
    logic        bit_event;
    logic        feedback;
    logic [14:0] crc_shift;
    logic        len_ok;

    // A bit is taken only on the first cycle of each enable-high period.
    assign bit_event = enable & ~edge_q;
    assign feedback  = Input ^ crc_q[14];
    assign crc_shift = {crc_q[13:0], 1'b0} ^ (feedback ? POLY : 15'h0000);

`ifdef RCRC_LENGTH_CHECK_EN
    localparam logic [6:0] MIN_BITS = 7'd15;
    localparam logic [6:0] CNT_MAX  = 7'd127;

    logic [6:0] cnt_q, cnt_d;

    assign len_ok = (cnt_q >= MIN_BITS);
    assign bitcnt = cnt_q;

    // Accepted-bit counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= 7'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign len_ok = 1'b1;
    assign bitcnt = 7'd0;
`endif

    // Edge flag simply follows enable; it tracks in every state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= enable;
        end
    end

    // State, CRC and result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            crc_q   <= 15'h0000;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: start has priority, then check, then a bit event.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        ok_d    = ok_q;
        err_d   = err_q;
`ifdef RCRC_LENGTH_CHECK_EN
        cnt_d   = cnt_q;
`endif
        if (start) begin
            state_d = CALC;
            crc_d   = 15'h0000;
            ok_d    = 1'b0;
            err_d   = 1'b0;
`ifdef RCRC_LENGTH_CHECK_EN
            cnt_d   = 7'd0;
`endif
        end else if (state_q == CALC) begin
            if (check) begin
                // A bit event coinciding with check is dropped.
                ok_d    = (crc_q == 15'h0000) && len_ok;
                err_d   = ~ok_d;
                state_d = DONE;
            end else if (bit_event) begin
                crc_d = crc_shift;
`ifdef RCRC_LENGTH_CHECK_EN
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 7'd1;
                end
`endif
            end
        end
    end

    assign crc     = crc_q;
    assign crc_ok  = ok_q;
    assign crc_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_crc15_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_crc15_unit
// Description : Self-checking bench for rx_crc15_unit. Expected CRC values
//               come from polynomial long division of the frame bits.
//               Honours RCRC_LENGTH_CHECK_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_crc15_unit;

`ifdef RCRC_LENGTH_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        enable;
    logic        Input;
    logic        check;
    logic [14:0] crc;
    logic        crc_ok;
    logic        crc_err;
    logic [6:0]  bitcnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit   m_bits[$];
    bit   m_calc;
    logic m_ok;
    logic m_err;

    rx_crc15_unit dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .enable  (enable),
        .Input   (Input),
        .check   (check),
        .crc     (crc),
        .crc_ok  (crc_ok),
        .crc_err (crc_err),
        .bitcnt  (bitcnt)
    );

    always #5 clock = ~clock;

    // Remainder of M(x)*x^15 divided by x^15 + 0x4599, by long division.
    function automatic logic [14:0] model_crc();
        int          n;
        bit          arr[$];
        logic [15:0] g;
        logic [14:0] r;
        n = m_bits.size();
        g = 16'hC599;
        foreach (m_bits[i]) arr.push_back(m_bits[i]);
        repeat (15) arr.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (arr[i]) begin
                for (int j = 0; j < 16; j++) arr[i + j] = arr[i + j] ^ g[15 - j];
            end
        end
        for (int k = 0; k < 15; k++) r[14 - k] = arr[n + k];
        return r;
    endfunction

    function automatic logic [6:0] model_cnt();
        if (!LEN_EN) return 7'd0;
        if (m_bits.size() > 127) return 7'd127;
        return 7'(m_bits.size());
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_calc = 1'b0;
        m_ok   = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_bits.delete();
        m_calc = 1'b1;
        m_ok   = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_check();
        if (m_calc) begin
            m_ok   = (model_crc() == 15'h0000) && (!LEN_EN || m_bits.size() >= 15);
            m_err  = ~m_ok;
            m_calc = 1'b0;
        end
    endtask

    task automatic do_check();
        check = 1'b1;
        tick();
        check = 1'b0;
        model_check();
    endtask

    // One enable-high period of 'hold' cycles; Input flips after the first
    // cycle so a second sample would corrupt the CRC.
    task automatic pulse_bit(input bit b, input int hold);
        enable = 1'b1;
        Input  = b;
        tick();
        if (m_calc) m_bits.push_back(b);
        Input = ~b;
        repeat (hold - 1) tick();
        enable = 1'b0;
        Input  = 1'($urandom);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; check = 1'b1; enable = 1'b0; Input = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enable = ~enable;
            tick();
        end
        model_reset();
        n_total++; if (crc !== 15'h0000) $display("FAIL reset_crc: got %h want 0000", crc); else n_pass++;
        n_total++; if ({crc_ok, crc_err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {crc_ok, crc_err}); else n_pass++;
        n_total++; if (bitcnt !== 7'd0) $display("FAIL reset_bitcnt: got %0d want 0", bitcnt); else n_pass++;
        reset = 1'b1; start = 1'b0; check = 1'b0; enable = 1'b0;
        tick();
        // IDLE ignores bits and check
        pulse_bit(1'b1, 1);
        n_total++; if (crc !== 15'h0000) $display("FAIL idle_bit_crc: got %h want 0000", crc); else n_pass++;
        do_check();
        n_total++; if ({crc_ok, crc_err} !== 2'b00) $display("FAIL idle_check_flags: got %b want 00", {crc_ok, crc_err}); else n_pass++;
    endtask

    task automatic test_known_vector();
        logic [14:0] c;
        c = 15'h4EAB;
        do_start();
        pulse_bit(1'b1, 1);
        n_total++; if (crc !== 15'h4599) $display("FAIL kv_bit1: got %h want 4599", crc); else n_pass++;
        pulse_bit(1'b0, 2);
        n_total++; if (crc !== 15'h4EAB) $display("FAIL kv_bit0: got %h want 4eab", crc); else n_pass++;
        for (int i = 14; i >= 0; i--) pulse_bit(c[i], 1);
        n_total++; if (crc !== 15'h0000) $display("FAIL kv_remainder: got %h want 0000", crc); else n_pass++;
        do_check();
        n_total++; if ({crc_ok, crc_err} !== 2'b10) $display("FAIL kv_flags: got %b want 10", {crc_ok, crc_err}); else n_pass++;
        n_total++; if (bitcnt !== (LEN_EN ? 7'd17 : 7'd0)) $display("FAIL kv_bitcnt: got %0d want %0d", bitcnt, LEN_EN ? 17 : 0); else n_pass++;
    endtask

    task automatic test_flip_and_hold();
        logic [14:0] c;
        logic [14:0] held;
        c = 15'h4EAB ^ (15'h0001 << $urandom_range(0, 14));
        do_start();
        pulse_bit(1'b1, 1);
        pulse_bit(1'b0, 1);
        for (int i = 14; i >= 0; i--) pulse_bit(c[i], 1);
        do_check();
        n_total++; if ({crc_ok, crc_err} !== 2'b01) $display("FAIL flip_flags: got %b want 01", {crc_ok, crc_err}); else n_pass++;
        n_total++; if (crc !== model_crc()) $display("FAIL flip_crc: got %h want %h", crc, model_crc()); else n_pass++;
        // DONE ignores further bits and check; results hold
        held = crc;
        pulse_bit(1'b1, 1);
        do_check();
        n_total++; if (crc !== held || {crc_ok, crc_err} !== 2'b01) $display("FAIL done_hold: got %h/%b want %h/01", crc, {crc_ok, crc_err}, held); else n_pass++;
        // Long enable-high period takes a single bit
        do_start();
        pulse_bit(1'b1, 10);
        n_total++; if (crc !== 15'h4599) $display("FAIL hold_crc: got %h want 4599", crc); else n_pass++;
        n_total++; if (bitcnt !== model_cnt()) $display("FAIL hold_bitcnt: got %0d want %0d", bitcnt, model_cnt()); else n_pass++;
    endtask

    task automatic test_priority();
        // start together with check: stays in frame with cleared results
        pulse_bit(1'b0, 1);
        start = 1'b1; check = 1'b1;
        tick();
        start = 1'b0; check = 1'b0;
        m_bits.delete(); m_calc = 1'b1; m_ok = 1'b0; m_err = 1'b0;
        n_total++; if (crc !== 15'h0000 || {crc_ok, crc_err} !== 2'b00) $display("FAIL start_check: got %h/%b want 0000/00", crc, {crc_ok, crc_err}); else n_pass++;
        pulse_bit(1'b1, 1);
        n_total++; if (crc !== 15'h4599) $display("FAIL start_check_calc: got %h want 4599", crc); else n_pass++;
        // start together with a rising enable: bit dropped, edge still consumed
        start = 1'b1; enable = 1'b1; Input = 1'b1;
        tick();
        start = 1'b0;
        m_bits.delete(); m_calc = 1'b1; m_ok = 1'b0; m_err = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        n_total++; if (crc !== 15'h0000 || bitcnt !== 7'd0) $display("FAIL start_bit: got %h/%0d want 0000/0", crc, bitcnt); else n_pass++;
        // check together with a rising enable: bit dropped
        for (int i = 0; i < 3; i++) pulse_bit(1'($urandom), 1);
        check = 1'b1; enable = 1'b1; Input = 1'b1;
        tick();
        check = 1'b0;
        model_check();
        enable = 1'b0;
        tick();
        n_total++; if (crc !== model_crc()) $display("FAIL check_bit_crc: got %h want %h", crc, model_crc()); else n_pass++;
        n_total++; if ({crc_ok, crc_err} !== {m_ok, m_err}) $display("FAIL check_bit_flags: got %b want %b", {crc_ok, crc_err}, {m_ok, m_err}); else n_pass++;
    endtask

    task automatic test_short_frame();
        do_start();
        for (int i = 0; i < 5; i++) pulse_bit(1'b0, 1);
        do_check();
        n_total++; if (crc !== 15'h0000) $display("FAIL short_crc: got %h want 0000", crc); else n_pass++;
        n_total++; if ({crc_ok, crc_err} !== (LEN_EN ? 2'b01 : 2'b10)) $display("FAIL short_flags: got %b want %b", {crc_ok, crc_err}, LEN_EN ? 2'b01 : 2'b10); else n_pass++;
    endtask

    task automatic test_reset_abort();
        do_start();
        for (int i = 0; i < 4; i++) pulse_bit(1'($urandom), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        n_total++; if (crc !== 15'h0000 || bitcnt !== 7'd0) $display("FAIL abort_clear: got %h/%0d want 0000/0", crc, bitcnt); else n_pass++;
        pulse_bit(1'b1, 1);
        do_check();
        n_total++; if (crc !== 15'h0000 || {crc_ok, crc_err} !== 2'b00) $display("FAIL abort_idle: got %h/%b want 0000/00", crc, {crc_ok, crc_err}); else n_pass++;
        do_start();
        pulse_bit(1'b1, 1);
        n_total++; if (crc !== 15'h4599) $display("FAIL abort_resume: got %h want 4599", crc); else n_pass++;
    endtask

    task automatic test_random_frames();
        logic [14:0] r;
        int          n;
        for (int f = 0; f < 8; f++) begin
            do_start();
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) begin
                pulse_bit(1'($urandom), $urandom_range(1, 4));
                n_total++; if (crc !== model_crc() || bitcnt !== model_cnt()) $display("FAIL rand_bit f%0d b%0d: got %h/%0d want %h/%0d", f, i, crc, bitcnt, model_crc(), model_cnt()); else n_pass++;
            end
            if ($urandom_range(0, 1) == 1) begin
                r = model_crc();
                for (int k = 14; k >= 0; k--) pulse_bit(r[k], $urandom_range(1, 3));
            end
            do_check();
            n_total++; if (crc !== model_crc() || {crc_ok, crc_err} !== {m_ok, m_err}) $display("FAIL rand_check f%0d: got %h/%b want %h/%b", f, crc, {crc_ok, crc_err}, model_crc(), {m_ok, m_err}); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        do_start();
        for (int i = 0; i < 130; i++) pulse_bit(1'($urandom), 1);
        n_total++; if (bitcnt !== model_cnt()) $display("FAIL sat_bitcnt: got %0d want %0d", bitcnt, model_cnt()); else n_pass++;
        n_total++; if (crc !== model_crc()) $display("FAIL sat_crc: got %h want %h", crc, model_crc()); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; enable = 1'b0; Input = 1'b0; check = 1'b0;
        model_reset();
        test_reset();
        test_known_vector();
        test_flip_and_hold();
        test_priority();
        test_short_frame();
        test_reset_abort();
        test_random_frames();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
